ball_ctrl: RTL
==============

# ball_ctrl

Target-ball controller for the reflex trainer, sitting directly upstream of the pixel generator. In GAME state it places a ball at a pseudo-random on-screen position, times its lifetime in frames, and detects mouse-click hits. It drives the per-pixel ball enable consumed by the pixel generator, and the hit score consumed by the digit renderers.

## Interface
- BALL_R, 16: ball radius in pixels (valid range 4..60).
- LIFETIME_FRAMES, 60: frames a ball stays up before counting as a miss.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.
- SCORE_MAX, 99: score saturation value.

Ports (name, direction, width, meaning):
- clk_25MHz  in  1  pixel clock; h_cnt/v_cnt advance one per cycle.
- rst_n  in  1  asynchronous, active-low reset.
- h_cnt  in  10  horizontal pixel counter (0..799).
- v_cnt  in  10  vertical line counter (0..524).
- MOUSE_X_POS  in  10  cursor x (0..639).
- MOUSE_Y_POS  in  10  cursor y (0..479).
- MOUSE_LEFT  in  1  left button level, already synchronous to clk_25MHz.
- game_state  in  1  0 = IDLE, 1 = GAME.
- enable_ball  out  1  registered; 1 when the current pixel lies inside the ball.
- ball_x  out  10  ball centre x.
- ball_y  out  10  ball centre y.
- score  out  7  hit count, 0..SCORE_MAX.
- hit_pulse  out  1  one-cycle pulse per hit.
- miss_pulse  out  1  one-cycle pulse per timeout.

## Operation
- Reset values:
  - All outputs 0.
  - State OFF.
  - LFSR = LFSR_SEED.
  - Frame counter 0.
  - Previous-button register 0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Steps every cycle regardless of state.
- Frame tick: one-cycle internal strobe when h_cnt==0 && v_cnt==0.
- Click event: MOUSE_LEFT==1 && previous MOUSE_LEFT==0. Only rising edges count; holding the button does not re-hit.
- States:
  - OFF:
    - ball hidden.
    - On game_state 0→1 (edge detected internally): score ← 0, go to SPAWN.
    - Score otherwise holds, so the IDLE screen can display it.
  - SPAWN:
    - Each cycle take candidate cx = lfsr[9:0], cy = lfsr[15:7] (9 bits, zero-extended).
    - Accept if BALL_R ≤ cx ≤ 639−BALL_R and BALL_R ≤ cy ≤ 479−BALL_R. On accept: latch ball_x/ball_y, clear frame counter, go to ACTIVE.
    - Otherwise retry next cycle (rejection sampling, no modulo).
  - ACTIVE:
    - Ball visible.
    - The frame counter increments on each frame tick.
    - Hit: a click event with dx²+dy² ≤ BALL_R², where dx = MOUSE_X_POS−ball_x and dy = MOUSE_Y_POS−ball_y, both signed 11-bit. Squares are 21-bit unsigned; the sum is 22-bit. On hit: hit_pulse=1, score+1 (saturating at SCORE_MAX), go to SPAWN.
    - Timeout: frame counter reaches LIFETIME_FRAMES. On timeout: miss_pulse=1, go to SPAWN.
    - A click outside the ball has no effect.
- game_state==0 in any state: go to OFF next cycle. enable_ball falls to 0; score holds.
- Simultaneous hit and timeout in the same cycle: the hit wins; only hit_pulse fires.
- enable_ball: registered form of (h_cnt<640 && v_cnt<480 && state==ACTIVE && (h_cnt−ball_x)²+(v_cnt−ball_y)² ≤ BALL_R²).

## Timing
- enable_ball lags h_cnt/v_cnt by exactly 1 cycle. The ball is drawn shifted 1 pixel right; this is accepted.
- Click event to hit_pulse/score update: 1 cycle (the edge register plus the state register).
- Hit to new ball visible: SPAWN takes ≥1 cycle. Expected rejection retries are below 3, but the count is unbounded by design. No output other than enable_ball depends on SPAWN duration.
- Timeout: miss_pulse asserts in the cycle after the LIFETIME_FRAMES-th frame tick since the spawn.
- rst_n assertion mid-operation: all state clears immediately (asynchronous). Release is synchronous-safe; the first action is OFF evaluation.

## Configuration
- MISS_PENALTY_EN:
  - Defined: each timeout also decrements score, saturating at 0.
  - Undefined: timeouts affect only miss_pulse; score only increments.
- The hit path is identical in both builds.

## Test plan
- Reset, then raise game_state, with BALL_R=16 and the default seed → within 20 cycles the state is ACTIVE, with 16≤ball_x≤623, 16≤ball_y≤463, and score=0.
- With the ball at (ball_x, ball_y): mouse at (ball_x+11, ball_y+11) (242 ≤ 256), one click → hit_pulse for 1 cycle, score=1, new ball spawned. Mouse at (ball_x+12, ball_y+12) (288 > 256) → no hit, score unchanged.
- Hold MOUSE_LEFT high for 1000 cycles inside the ball → exactly one hit.
- No clicks for 60 frame ticks → one miss_pulse and a respawn. Score unchanged without MISS_PENALTY_EN; score 5→4 with it; score 0 stays 0.
- Force a click inside the ball in the same cycle as the 60th-frame timeout → hit_pulse=1, miss_pulse=0. Score at 99 plus one hit → stays 99.
- Drop game_state mid-ACTIVE → enable_ball=0 next cycle and score held. Pulse rst_n low mid-SPAWN → all outputs 0 immediately.

Source files
------------

// File: rtl/ball_ctrl.sv
// rtl/ball_ctrl.sv - target-ball spawn, lifetime timing and click-hit detection
// Optional feature macro MISS_PENALTY_EN: each timeout also decrements score, saturating at 0.
module ball_ctrl #(
    parameter int          BALL_R          = 16,
    parameter int          LIFETIME_FRAMES = 60,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int          SCORE_MAX       = 99
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic [9:0] MOUSE_X_POS,
    input  logic [9:0] MOUSE_Y_POS,
    input  logic       MOUSE_LEFT,
    input  logic       game_state,
    output logic       enable_ball,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [6:0] score,
    output logic       hit_pulse,
    output logic       miss_pulse
);
    localparam int              FW         = $clog2(LIFETIME_FRAMES + 1);
    localparam logic [21:0]     R_SQ       = 22'(BALL_R * BALL_R);
    localparam logic [9:0]      POS_MIN    = 10'(BALL_R);
    localparam logic [9:0]      X_MAX      = 10'(639 - BALL_R);
    localparam logic [9:0]      Y_MAX      = 10'(479 - BALL_R);
    localparam logic [FW-1:0]   LAST_FRAME = FW'(LIFETIME_FRAMES - 1);
    localparam logic [6:0]      SCORE_TOP  = 7'(SCORE_MAX);

    typedef enum logic [1:0] {ST_OFF, ST_SPAWN, ST_ACTIVE} state_t;

    state_t        r_state, w_state_nxt;
    logic [15:0]   r_lfsr;
    logic [FW-1:0] r_frame_cnt, w_frame_nxt;
    logic          r_prev_left, r_prev_game;
    logic [9:0]    r_ball_x, r_ball_y, w_ball_x_nxt, w_ball_y_nxt;
    logic [6:0]    r_score, w_score_nxt;
    logic          r_hit, r_miss, r_enable;
    logic          w_hit, w_miss, w_pix_in, w_mouse_in;
    logic          w_click, w_tick, w_accept;
    logic [9:0]    w_cand_x, w_cand_y;

    // Squared Euclidean distance with signed 11-bit deltas, 21-bit squares, 22-bit sum.
    function automatic logic [21:0] dist_sq(input logic [9:0] a_x, input logic [9:0] a_y,
                                            input logic [9:0] b_x, input logic [9:0] b_y);
        logic signed [10:0] dx, dy;
        logic [20:0]        mx, my;
        dx = $signed({1'b0, a_x}) - $signed({1'b0, b_x});
        dy = $signed({1'b0, a_y}) - $signed({1'b0, b_y});
        mx = dx[10] ? 21'(-dx) : 21'(dx);
        my = dy[10] ? 21'(-dy) : 21'(dy);
        return {1'b0, 21'(mx * mx)} + {1'b0, 21'(my * my)};
    endfunction

    assign w_click    = MOUSE_LEFT & ~r_prev_left;
    assign w_tick     = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign w_cand_x   = r_lfsr[9:0];
    assign w_cand_y   = {1'b0, r_lfsr[15:7]};
    assign w_accept   = (w_cand_x >= POS_MIN) && (w_cand_x <= X_MAX) &&
                        (w_cand_y >= POS_MIN) && (w_cand_y <= Y_MAX);
    assign w_mouse_in = dist_sq(MOUSE_X_POS, MOUSE_Y_POS, r_ball_x, r_ball_y) <= R_SQ;
    assign w_pix_in   = (h_cnt < 10'd640) && (v_cnt < 10'd480) && (r_state == ST_ACTIVE) &&
                        (dist_sq(h_cnt, v_cnt, r_ball_x, r_ball_y) <= R_SQ);

    always_comb begin
        w_state_nxt  = r_state;
        w_frame_nxt  = r_frame_cnt;
        w_ball_x_nxt = r_ball_x;
        w_ball_y_nxt = r_ball_y;
        w_score_nxt  = r_score;
        w_hit        = 1'b0;
        w_miss       = 1'b0;
        if (!game_state) begin
            w_state_nxt = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (!r_prev_game) begin
                        w_score_nxt = '0;
                        w_state_nxt = ST_SPAWN;
                    end
                end
                ST_SPAWN: begin
                    // Rejection sampling keeps the position distribution free of modulo bias.
                    if (w_accept) begin
                        w_ball_x_nxt = w_cand_x;
                        w_ball_y_nxt = w_cand_y;
                        w_frame_nxt  = '0;
                        w_state_nxt  = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_tick) w_frame_nxt = r_frame_cnt + 1'b1;
                    if (w_click && w_mouse_in) begin
                        w_hit       = 1'b1;
                        w_state_nxt = ST_SPAWN;
                        if (r_score < SCORE_TOP) w_score_nxt = r_score + 7'd1;
                    end else if (w_tick && (r_frame_cnt == LAST_FRAME)) begin
                        w_miss      = 1'b1;
                        w_state_nxt = ST_SPAWN;
`ifdef MISS_PENALTY_EN
                        if (r_score != 7'd0) w_score_nxt = r_score - 7'd1;
`endif
                    end
                end
                default: w_state_nxt = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_OFF;
            r_lfsr      <= LFSR_SEED;
            r_frame_cnt <= '0;
            r_prev_left <= 1'b0;
            r_prev_game <= 1'b0;
            r_ball_x    <= '0;
            r_ball_y    <= '0;
            r_score     <= '0;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
            r_enable    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lfsr      <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_frame_cnt <= w_frame_nxt;
            r_prev_left <= MOUSE_LEFT;
            r_prev_game <= game_state;
            r_ball_x    <= w_ball_x_nxt;
            r_ball_y    <= w_ball_y_nxt;
            r_score     <= w_score_nxt;
            r_hit       <= w_hit;
            r_miss      <= w_miss;
            r_enable    <= w_pix_in;
        end
    end

    assign enable_ball = r_enable;
    assign ball_x      = r_ball_x;
    assign ball_y      = r_ball_y;
    assign score       = r_score;
    assign hit_pulse   = r_hit;
    assign miss_pulse  = r_miss;
endmodule
